// File: rtl/gravador_sequencia_pkg.sv
// Shared definitions for the sequence recorder: state encoding and timeout defaults.
`timescale 1ns/1ps
package gravador_sequencia_pkg;

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    ESPERA   = 3'd1,
    ESCREVE  = 3'd2,
    SOLTA    = 3'd3,
    FIM      = 3'd4,
    EXPIRADO = 3'd5
  } estado_t;

  localparam int CLOCK_FREQ_PADRAO = 5000;
  localparam int TIMEOUT_S_PADRAO  = 3;
  localparam int TIMEOUT_CICLOS    = TIMEOUT_S_PADRAO * CLOCK_FREQ_PADRAO;

  // Timer width for a given cycle count; never narrower than one bit.
  function automatic int larguraTimer(input int ciclos);
    return (ciclos <= 2) ? 1 : $clog2(ciclos);
  endfunction

endpackage

// File: rtl/sync_ram_16x4.sv
// Simple dual-port RAM: one write port and one registered read port (read-before-write).
`timescale 1ns/1ps
module sync_ram_16x4 #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [DATA_W-1:0] rdData
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Array has no reset so it keeps its contents across reset_n.
  always_ff @(posedge clock) begin
    if (we) mem[addr] <= din;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rdData <= '0;
    else          rdData <= mem[rdAddr];
  end

endmodule

// File: rtl/gravador_sequencia.sv
// Records one-hot button presses into a small RAM; recording ends on finalizar, full memory or inactivity.
`timescale 1ns/1ps
module gravador_sequencia
  import gravador_sequencia_pkg::*;
#(
  parameter int CLOCK_FREQ = CLOCK_FREQ_PADRAO,
  parameter int TIMEOUT_S  = TIMEOUT_S_PADRAO,
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              iniciar,
  input  logic              finalizar,
  input  logic [DATA_W-1:0] botoes,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] tamanho,
  output logic              pronto,
  output logic              gravando,
  output logic              timeout,
  output logic              erro_botao,
  output logic [DATA_W-1:0] leds,
  output logic [2:0]        db_estado
);

  localparam int CICLOS  = TIMEOUT_S * CLOCK_FREQ;
  localparam int TIMER_W = larguraTimer(CICLOS);
  localparam logic [TIMER_W-1:0] TIMER_FIM = TIMER_W'(CICLOS - 1);

  estado_t             estado, proximo;
  logic [ADDR_W:0]     contador;
  logic [TIMER_W-1:0]  timer;
  logic [DATA_W-1:0]   captura;
  logic                botaoAntes;
  logic                novoToque, umSo, temEntrada, fimTimer;
  logic                limpar, escrever, capturar, erroBotao;

  // iniciar/finalizar are single-cycle pulses; a press is the rising edge of any button.
  assign novoToque  = (|botoes) && !botaoAntes;
  assign umSo       = (botoes != '0) && ((botoes & (botoes - 1'b1)) == '0);
  assign temEntrada = (contador != '0);
  assign fimTimer   = (timer == TIMER_FIM);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) estado <= OCIOSO;
    else          estado <= proximo;
  end

  always_comb begin
    proximo   = estado;
    limpar    = 1'b0;
    escrever  = 1'b0;
    capturar  = 1'b0;
    erroBotao = 1'b0;
    case (estado)
      OCIOSO, FIM, EXPIRADO: begin
        if (iniciar) begin
          proximo = ESPERA;
          limpar  = 1'b1;
        end
      end
      ESPERA: begin
        if (novoToque && umSo) begin
          proximo  = ESCREVE;
          capturar = 1'b1;
        end else begin
          erroBotao = novoToque;
          if (finalizar && temEntrada) proximo = FIM;
          else if (fimTimer)           proximo = temEntrada ? FIM : EXPIRADO;
        end
      end
      ESCREVE: begin
        escrever = 1'b1;
        proximo  = SOLTA;
      end
      SOLTA: begin
        if (botoes == '0) proximo = contador[ADDR_W] ? FIM : ESPERA;
      end
      default: proximo = OCIOSO;
    endcase
  end

  // Timer runs only while staying in ESPERA, so any entry into ESPERA starts it at zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      contador   <= '0;
      tamanho    <= '0;
      timer      <= '0;
      captura    <= '0;
      botaoAntes <= 1'b0;
    end else begin
      botaoAntes <= |botoes;
      if (capturar) captura <= botoes;
      if (limpar) begin
        contador <= '0;
        tamanho  <= '0;
      end else if (escrever) begin
        tamanho  <= contador[ADDR_W-1:0];
        contador <= contador + 1'b1;
      end
      if (estado == ESPERA && proximo == ESPERA) timer <= timer + 1'b1;
      else                                       timer <= '0;
    end
  end

  sync_ram_16x4 #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clock  (clock),
    .reset_n(reset_n),
    .we     (escrever),
    .addr   (contador[ADDR_W-1:0]),
    .din    (captura),
    .rdAddr (rd_addr),
    .rdData (rd_data)
  );

  assign pronto     = (estado == FIM);
  assign timeout    = (estado == EXPIRADO);
  assign gravando   = (estado == ESPERA) || (estado == ESCREVE) || (estado == SOLTA);
  assign leds       = ((estado == ESCREVE) || (estado == SOLTA)) ? captura : '0;
  assign erro_botao = erroBotao;
  assign db_estado  = estado;

endmodule

// File: tb/tb_gravador_sequencia.sv
// Directed bench for gravador_sequencia: recording, timeout, full memory, invalid press, async reset.
`timescale 1ns/1ps
module tb_gravador_sequencia;

  logic       clock;
  logic       reset_n;
  logic       iniciar;
  logic       finalizar;
  logic [3:0] botoes;
  logic [3:0] rd_addr;
  logic [3:0] rd_data;
  logic [3:0] tamanho;
  logic       pronto;
  logic       gravando;
  logic       timeout;
  logic       erro_botao;
  logic [3:0] leds;
  logic [2:0] db_estado;

  int checks = 0;
  int errors = 0;

  gravador_sequencia dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .iniciar   (iniciar),
    .finalizar (finalizar),
    .botoes    (botoes),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .tamanho   (tamanho),
    .pronto    (pronto),
    .gravando  (gravando),
    .timeout   (timeout),
    .erro_botao(erro_botao),
    .leds      (leds),
    .db_estado (db_estado)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic verificar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    if (obs !== esp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, esp, $time);
    end
  endtask

  // driver tasks: all driving and sampling happens at the falling edge
  task automatic passo(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulsoIniciar();
    iniciar = 1'b1;
    passo(1);
    iniciar = 1'b0;
  endtask

  task automatic pulsoFinalizar();
    finalizar = 1'b1;
    passo(1);
    finalizar = 1'b0;
  endtask

  task automatic pressionar(input logic [3:0] b);
    botoes = b;
    passo(1);
    verificar("leds_eco", 32'(leds), 32'(b));
    passo(2);
    botoes = 4'b0000;
    passo(1);
  endtask

  task automatic lerRam(input logic [3:0] a, input logic [3:0] esp);
    rd_addr = a;
    passo(1);
    verificar("rd_data", 32'(rd_data), 32'(esp));
  endtask

  initial begin
    logic [3:0] v;
    reset_n = 1'b0; iniciar = 1'b0; finalizar = 1'b0; botoes = 4'b0000; rd_addr = 4'd0;
    #3;
    verificar("rst_estado",   32'(db_estado), 32'd0);
    verificar("rst_pronto",   32'(pronto),    32'd0);
    verificar("rst_gravando", 32'(gravando),  32'd0);
    verificar("rst_timeout",  32'(timeout),   32'd0);
    verificar("rst_tamanho",  32'(tamanho),   32'd0);
    verificar("rst_rd_data",  32'(rd_data),   32'd0);
    verificar("rst_leds",     32'(leds),      32'd0);
    passo(2);
    reset_n = 1'b1;
    passo(1);

    // three presses then finalizar
    pulsoIniciar();
    verificar("t1_espera",   32'(db_estado), 32'd1);
    verificar("t1_gravando", 32'(gravando),  32'd1);
    pressionar(4'b0001);
    pressionar(4'b0100);
    pressionar(4'b1000);
    verificar("t1_volta_espera", 32'(db_estado), 32'd1);
    pulsoFinalizar();
    verificar("t1_fim",      32'(db_estado), 32'd4);
    verificar("t1_pronto",   32'(pronto),    32'd1);
    verificar("t1_gravando0",32'(gravando),  32'd0);
    verificar("t1_tamanho",  32'(tamanho),   32'd2);
    lerRam(4'd0, 4'b0001);
    lerRam(4'd1, 4'b0100);
    lerRam(4'd2, 4'b1000);

    // timeout with zero entries
    pulsoIniciar();
    verificar("t2_pronto0",  32'(pronto),    32'd0);
    verificar("t2_tamanho0", 32'(tamanho),   32'd0);
    passo(14999);
    verificar("t2_ainda_espera", 32'(db_estado), 32'd1);
    passo(1);
    verificar("t2_expirado", 32'(db_estado), 32'd5);
    verificar("t2_timeout",  32'(timeout),   32'd1);
    verificar("t2_pronto",   32'(pronto),    32'd0);
    pulsoIniciar();
    verificar("t2_timeout0", 32'(timeout),   32'd0);
    verificar("t2_espera",   32'(db_estado), 32'd1);

    // one entry then inactivity
    pressionar(4'b0010);
    passo(14999);
    verificar("t3_ainda_espera", 32'(db_estado), 32'd1);
    passo(1);
    verificar("t3_fim",     32'(db_estado), 32'd4);
    verificar("t3_pronto",  32'(pronto),    32'd1);
    verificar("t3_tamanho", 32'(tamanho),   32'd0);
    lerRam(4'd0, 4'b0010);

    // fill all 16 entries
    pulsoIniciar();
    for (int i = 0; i < 16; i++) begin
      v = 4'b0001 << (i % 4);
      pressionar(v);
      if (i == 14) verificar("t4_espera_15", 32'(db_estado), 32'd1);
    end
    verificar("t4_fim",     32'(db_estado), 32'd4);
    verificar("t4_pronto",  32'(pronto),    32'd1);
    verificar("t4_tamanho", 32'(tamanho),   32'd15);
    botoes = 4'b1000;
    passo(3);
    verificar("t4_extra_ignorado", 32'(db_estado), 32'd4);
    verificar("t4_extra_leds",     32'(leds),      32'd0);
    botoes = 4'b0000;
    passo(1);
    lerRam(4'd0,  4'b0001);
    lerRam(4'd1,  4'b0010);
    lerRam(4'd15, 4'b1000);

    // invalid multi-button press
    pulsoIniciar();
    pressionar(4'b0100);
    botoes = 4'b0011;
    #1;
    verificar("t5_erro_pulso", 32'(erro_botao), 32'd1);
    passo(1);
    verificar("t5_erro_fim",   32'(erro_botao), 32'd0);
    verificar("t5_espera",     32'(db_estado),  32'd1);
    verificar("t5_tamanho",    32'(tamanho),    32'd0);
    botoes = 4'b0000;
    passo(1);
    pressionar(4'b0001);
    pulsoFinalizar();
    verificar("t5_pronto",  32'(pronto),  32'd1);
    verificar("t5_tamanho1",32'(tamanho), 32'd1);
    lerRam(4'd0, 4'b0100);
    lerRam(4'd1, 4'b0001);

    // asynchronous reset while in SOLTA
    pulsoIniciar();
    botoes = 4'b0010;
    passo(2);
    verificar("t6_solta",      32'(db_estado), 32'd3);
    verificar("t6_leds_solta", 32'(leds),      32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    verificar("t6_rst_estado",   32'(db_estado), 32'd0);
    verificar("t6_rst_gravando", 32'(gravando),  32'd0);
    verificar("t6_rst_leds",     32'(leds),      32'd0);
    verificar("t6_rst_rd_data",  32'(rd_data),   32'd0);
    botoes = 4'b0000;
    passo(1);
    reset_n = 1'b1;
    lerRam(4'd0, 4'b0010);
    lerRam(4'd1, 4'b0001);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gravador_sequencia.md
Name: gravador_sequencia

Overview:
Records a player-entered sequence of button presses into an internal 16x4 synchronous RAM, so the game can replay a custom sequence instead of the fixed ROM. It is the writer side of the sequence memory: the game datapath reads it through a synchronous read port with the same timing as the ROM. A recording ends in one of three ways: explicit finish, memory full, or inactivity timeout.

Parameters:
CLOCK_FREQ, 5000, clock cycles per second; sets the timeout base.
TIMEOUT_S, 3, seconds of inactivity in ESPERA before the timeout fires.
ADDR_W, 4, address width; depth = 2**ADDR_W = 16.
DATA_W, 4, word width; equals the number of buttons.

Ports:
clock  in  1  system clock; all logic is rising-edge.
reset_n  in  1  asynchronous, active-low reset.
iniciar  in  1  one-cycle pulse that starts a new recording.
finalizar  in  1  one-cycle pulse that ends the recording.
botoes  in  DATA_W  raw button levels, already synchronised.
rd_addr  in  ADDR_W  read address from the game datapath.
rd_data  out  DATA_W  RAM word at rd_addr, registered.
tamanho  out  ADDR_W  last valid address, i.e. entry count minus 1.
pronto  out  1  a valid sequence of 1 or more entries is stored.
gravando  out  1  high in ESPERA, ESCREVE and SOLTA.
timeout  out  1  recording ended with zero entries; held until the next iniciar.
erro_botao  out  1  one-cycle pulse on an ignored multi-button press.
leds  out  DATA_W  echo of the captured press; high only in ESCREVE and SOLTA.
db_estado  out  3  state encoding for debug.

Behaviour:
- Reset (async, reset_n=0): state OCIOSO. Entry counter, tamanho, timer = 0. pronto, gravando, timeout, erro_botao, leds = 0. rd_data = 0. RAM contents are not cleared.
- Press detection: rising edge of |botoes, using a 1-cycle registered delay of |botoes.
  - A press is valid only if botoes is one-hot.
  - A non-one-hot press pulses erro_botao for 1 cycle and writes nothing.
- States:
  - OCIOSO: iniciar -> ESPERA. Counter = 0, timer = 0, pronto = 0, timeout = 0.
  - ESPERA: timer counts.
    - Valid press: latch botoes into the capture register -> ESCREVE.
    - finalizar with count>=1 -> FIM. finalizar with count=0 is ignored.
    - Timer reaches TIMEOUT_S*CLOCK_FREQ-1 with count>=1 -> FIM; with count=0 -> EXPIRADO.
    - Press and timer terminal on the same cycle: the press wins.
    - Press and finalizar on the same cycle: the press wins and finalizar is dropped.
  - ESCREVE (1 cycle): RAM[count] <= capture; tamanho <= count; count <= count+1 -> SOLTA.
  - SOLTA: wait for botoes==0, then:
    - count==16 -> FIM (memory full; count saturates internally at 16, tamanho = 15).
    - otherwise -> ESPERA with timer cleared.
    - Timer is held at 0 in SOLTA.
  - FIM: pronto = 1, gravando = 0. iniciar -> ESPERA; counter is cleared and pronto drops the next cycle.
  - EXPIRADO: timeout = 1, pronto = 0. iniciar -> ESPERA.
- iniciar in ESPERA, ESCREVE or SOLTA is ignored.
- Read port:
  - rd_data <= RAM[rd_addr] every cycle, so latency is 1 cycle.
  - A read and a write to the same address in the same cycle return the old data (read-before-write).
  - Reads are allowed in every state.
- Timer width: clog2(TIMEOUT_S*CLOCK_FREQ); 14 bits at the defaults. The timer is cleared on entry to ESPERA.
- tamanho is only meaningful when pronto = 1. It keeps its old value through EXPIRADO and is set to 0 on iniciar.
- State encoding (db_estado): OCIOSO=0, ESPERA=1, ESCREVE=2, SOLTA=3, FIM=4, EXPIRADO=5. Any other code -> OCIOSO.

Decomposition:
- Shared package: state encoding constants, default CLOCK_FREQ, and the timeout cycle count as the constant TIMEOUT_S*CLOCK_FREQ.
- Sub-module sync_ram_16x4: one write port (we, addr, din) and one independent registered read port.
- FSM, counter, timer and edge detection stay in gravador_sequencia.

Test Plan:
- Reset, iniciar, presses 0001, 0100, 1000 (each released), then finalizar -> pronto=1, tamanho=2; reading rd_addr 0,1,2 gives 0001, 0100, 1000, each one cycle after the address.
- iniciar, then no press for 15000 cycles -> EXPIRADO on cycle 15000, timeout=1, pronto=0; a following iniciar clears timeout.
- iniciar, one press of 0010, then idle 15000 cycles -> FIM, pronto=1, tamanho=0, RAM[0]=0010.
- 16 valid presses -> automatic FIM after the 16th release, tamanho=15; a 17th press is ignored and RAM[0] is unchanged.
- Press 0011 in ESPERA -> erro_botao pulses once, tamanho unchanged, still ESPERA; a following 0001 is stored at the current address.
- Drive reset_n low while in SOLTA -> outputs go to 0 immediately (asynchronously); RAM contents from before the reset still read back via rd_addr.
